// File: rtl/fft_ip_feeder.sv
// Frame assembler for the radix-2 SDF fft core: buffers 2^N samples per frame in a
// ping-pong memory and replays each frame as a gapless burst with a start pulse.
module fft_ip_feeder #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_flush,
  output logic [W-1:0] op_data,
  output logic         op_start,
  output logic         op_valid,
  output logic [15:0]  frame_cnt
);

  localparam int unsigned L     = 1 << N;
  localparam int unsigned IDX_W = N;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(L - 1);
  localparam logic [IDX_W-1:0] FIRST_IDX = '0;

  typedef enum logic {WR_FILL, WR_PAD} wr_state_e;
  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_e;

  wr_state_e        wr_state;
  rd_state_e        rd_state;
  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       bank_full;

  logic [W-1:0]     mem [2][L];

  logic             accept;
  logic             wr_last;
  logic [IDX_W-1:0] wr_idx_after;
  logic             mem_we;
  logic [W-1:0]     mem_wdata;
  logic [1:0]       wr_set;
  logic [1:0]       rd_clr;

  // Write-side handshake, memory write port and bank flag set/clear requests
  always_comb begin
    in_ready     = !bank_full[wr_bank] && (wr_state == WR_FILL);
    accept       = in_valid && in_ready;
    wr_last      = (wr_idx == LAST_IDX);
    wr_idx_after = accept ? wr_idx + IDX_W'(1) : wr_idx;
    mem_we       = 1'b0;
    mem_wdata    = in_data;
    wr_set       = 2'b00;
    rd_clr       = 2'b00;
    case (wr_state)
      WR_FILL: begin
        if (accept) begin
          mem_we = 1'b1;
          if (wr_last) wr_set[wr_bank] = 1'b1;
        end
      end
      WR_PAD: begin
        mem_we    = 1'b1;
        mem_wdata = '0;
        if (wr_last) wr_set[wr_bank] = 1'b1;
      end
      default: ;
    endcase
    if (rd_state == RD_STREAM && rd_idx == LAST_IDX) rd_clr[rd_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_bank][wr_idx] <= mem_wdata;
  end

  // Write and read FSMs; the two banks' full flags are the only shared state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state  <= WR_FILL;
      rd_state  <= RD_IDLE;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      bank_full <= 2'b00;
      op_data   <= '0;
      op_start  <= 1'b0;
      op_valid  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      bank_full <= (bank_full | wr_set) & ~rd_clr;

      case (wr_state)
        WR_FILL: begin
          if (accept) begin
            wr_idx <= wr_idx + IDX_W'(1);
            if (wr_last) wr_bank <= ~wr_bank;
          end
          // A flush that lands on a frame boundary has nothing to pad
          if (in_flush && wr_idx_after != FIRST_IDX) wr_state <= WR_PAD;
        end
        WR_PAD: begin
          wr_idx <= wr_idx + IDX_W'(1);
          if (wr_last) begin
            wr_bank  <= ~wr_bank;
            wr_state <= WR_FILL;
          end
        end
        default: wr_state <= WR_FILL;
      endcase

      case (rd_state)
        RD_IDLE: begin
          if (bank_full[rd_bank]) begin
            rd_state <= RD_STREAM;
            op_valid <= 1'b1;
            op_start <= 1'b1;
            op_data  <= mem[rd_bank][FIRST_IDX];
            rd_idx   <= IDX_W'(1);
          end
        end
        RD_STREAM: begin
          // rd_idx wraps to zero only on the edge after the last sample went out
          if (rd_idx == FIRST_IDX) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (bank_full[rd_bank]) begin
              op_start <= 1'b1;
              op_data  <= mem[rd_bank][FIRST_IDX];
              rd_idx   <= IDX_W'(1);
            end else begin
              op_start <= 1'b0;
              op_valid <= 1'b0;
              op_data  <= '0;
              rd_state <= RD_IDLE;
            end
          end else begin
            op_start <= 1'b0;
            op_data  <= mem[rd_bank][rd_idx];
            rd_idx   <= rd_idx + IDX_W'(1);
            if (rd_idx == LAST_IDX) rd_bank <= ~rd_bank;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_ip_feeder.sv
// Bench for fft_ip_feeder: directed and random traffic checked against a queue model
// of the emitted sample stream and frame count.
module tb_fft_ip_feeder;
  localparam int unsigned N = 3;
  localparam int unsigned W = 16;
  localparam int unsigned L = 1 << N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_flush = 1'b0;
  logic [W-1:0] op_data;
  logic         op_start;
  logic         op_valid;
  logic [15:0]  frame_cnt;

  fft_ip_feeder #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_flush(in_flush), .op_data(op_data),
    .op_start(op_start), .op_valid(op_valid), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  // Monitor-owned observations
  logic [W-1:0] got_q[$];
  int valid_cycles = 0;
  int runs = 0;
  int start_err = 0;
  int drop_err = 0;

  // Model-owned state
  logic [W-1:0] exp_q[$];
  int part = 0;
  int exp_frames = 0;
  int gb = 0;
  int eb = 0;

  initial begin : monitor
    int pos;
    logic prev_v;
    pos = 0;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pos = 0;
        prev_v = 1'b0;
      end else begin
        if (op_valid) begin
          got_q.push_back(op_data);
          valid_cycles++;
          if (!prev_v) runs++;
          if (op_start !== ((pos % L) == 0)) start_err++;
          pos++;
        end else begin
          if ((pos % L) != 0) drop_err++;
          if (op_start) start_err++;
          pos = 0;
        end
        prev_v = op_valid;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic negs();
    @(negedge clk);
    #1;
  endtask

  task automatic m_flush();
    if (part > 0) begin
      repeat (L - part) exp_q.push_back('0);
      part = 0;
      exp_frames++;
    end
  endtask

  task automatic m_accept(input logic [W-1:0] d, input logic fl);
    exp_q.push_back(d);
    part++;
    if (part == L) begin
      part = 0;
      exp_frames++;
    end
    if (fl) m_flush();
  endtask

  task automatic send(input logic [W-1:0] d, input logic fl);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_flush = fl;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("send_ready", 32'(in_ready), 32'd1);
    if (in_ready) m_accept(d, fl);
    step();
    in_valid = 1'b0;
    in_flush = 1'b0;
  endtask

  task automatic flush_only();
    in_flush = 1'b1;
    m_flush();
    step();
    in_flush = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    int target;
    n = 0;
    target = gb + (exp_q.size() - eb);
    negs();
    while ((got_q.size() < target || op_valid) && n < 300) begin
      n++;
      negs();
    end
    check({tag, "_drain"}, 32'(got_q.size()), 32'(target));
  endtask

  task automatic check_stream(input string tag);
    int ng;
    int ne;
    ng = got_q.size() - gb;
    ne = exp_q.size() - eb;
    check({tag, "_len"}, 32'(ng), 32'(ne));
    for (int i = 0; i < ng && i < ne; i++)
      check($sformatf("%s_d%0d", tag, i), 32'(got_q[gb + i]), 32'(exp_q[eb + i]));
    gb = got_q.size();
    eb = exp_q.size();
  endtask

  initial begin : main
    int v0, r0, s0, d0, n, pre;
    logic fl;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_op_start", 32'(op_start), 32'd0);
    check("rst_op_data", 32'(op_data), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    repeat (5) negs();
    check("idle_op_valid", 32'(op_valid), 32'd0);
    check("idle_vcycles", 32'(valid_cycles), 32'd0);
    step();

    // Single frame with latency
    v0 = valid_cycles; r0 = runs; s0 = start_err;
    for (int i = 1; i <= 8; i++) send(W'(i), 1'b0);
    @(negedge clk);
    check("lat_pre_valid", 32'(op_valid), 32'd0);
    @(negedge clk);
    check("lat_start", 32'(op_start), 32'd1);
    check("lat_data", 32'(op_data), 32'd1);
    wait_drain("single");
    check_stream("single");
    check("single_vcycles", 32'(valid_cycles - v0), 32'd8);
    check("single_runs", 32'(runs - r0), 32'd1);
    check("single_starts", 32'(start_err - s0), 32'd0);
    check("single_frames", 32'(frame_cnt), 32'(exp_frames));
    step();

    // Continuous stream of three frames
    v0 = valid_cycles; r0 = runs; s0 = start_err; d0 = drop_err;
    for (int i = 1; i <= 24; i++) send(W'(i), 1'b0);
    wait_drain("cont");
    check_stream("cont");
    check("cont_vcycles", 32'(valid_cycles - v0), 32'd24);
    check("cont_runs", 32'(runs - r0), 32'd1);
    check("cont_starts", 32'(start_err - s0), 32'd0);
    check("cont_drops", 32'(drop_err - d0), 32'd0);
    check("cont_frames", 32'(frame_cnt), 32'(exp_frames));
    step();

    // Max-rate burst of 20 random samples, remainder flushed out
    s0 = start_err; d0 = drop_err;
    for (int i = 0; i < 20; i++) send(W'($urandom), 1'b0);
    flush_only();
    wait_drain("burst");
    check_stream("burst");
    check("burst_starts", 32'(start_err - s0), 32'd0);
    check("burst_drops", 32'(drop_err - d0), 32'd0);
    check("burst_frames", 32'(frame_cnt), 32'(exp_frames));
    step();

    // Flush of a three-sample partial frame
    send(W'(5), 1'b0);
    send(W'(6), 1'b0);
    send(W'(7), 1'b0);
    pre = part;
    flush_only();
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("flush_ready_low", 32'(n), 32'(L - pre));
    wait_drain("flush");
    check_stream("flush");
    check("flush_frames", 32'(frame_cnt), 32'(exp_frames));
    step();

    // Flush on a frame boundary emits nothing
    v0 = valid_cycles;
    flush_only();
    repeat (20) negs();
    check("flush0_vcycles", 32'(valid_cycles - v0), 32'd0);
    check("flush0_frames", 32'(frame_cnt), 32'(exp_frames));
    check("flush0_ready", 32'(in_ready), 32'd1);
    step();

    // Random gaps, random data, occasional flush riding on a sample
    s0 = start_err; d0 = drop_err;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) step();
      fl = ($urandom_range(0, 9) == 0);
      send(W'($urandom), fl);
    end
    flush_only();
    wait_drain("rand");
    check_stream("rand");
    check("rand_starts", 32'(start_err - s0), 32'd0);
    check("rand_drops", 32'(drop_err - d0), 32'd0);
    check("rand_frames", 32'(frame_cnt), 32'(exp_frames));
    step();

    // Asynchronous reset while the fourth output sample is on the bus
    for (int i = 1; i <= 8; i++) send(W'(i), 1'b0);
    n = 0;
    negs();
    while (got_q.size() < gb + 4 && n < 100) begin
      n++;
      negs();
    end
    check("mid_reached", 32'(got_q.size() - gb), 32'd4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(op_valid), 32'd0);
    check("mid_rst_start", 32'(op_start), 32'd0);
    check("mid_rst_data", 32'(op_data), 32'd0);
    check("mid_rst_frames", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    exp_q.delete();
    part = 0;
    exp_frames = 0;
    gb = got_q.size();
    eb = 0;
    r0 = runs; s0 = start_err; d0 = drop_err;
    for (int i = 11; i <= 18; i++) send(W'(i), 1'b0);
    wait_drain("post");
    check_stream("post");
    check("post_runs", 32'(runs - r0), 32'd1);
    check("post_starts", 32'(start_err - s0), 32'd0);
    check("post_drops", 32'(drop_err - d0), 32'd0);
    check("post_frames", 32'(frame_cnt), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
